// File: rtl/uart_prog_loader.sv
// Program-load sequencer: packs UART bytes into little-endian words and writes them to memory.
// Optional idle timeout in COLLECT is enabled by defining UART_PROG_TIMEOUT_EN.
module uart_prog_loader #(
  parameter logic [15:0] CLKS_PER_BIT_DEF = 16'd87,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter logic [31:0] END_WORD         = 32'h0000_0FFF,
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd1_000_000
) (
  input  logic        i_Clock,
  input  logic        rst_ni,
  input  logic        i_Start,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [15:0] o_Clks_Per_Bit,
  output logic        o_Mem_Req,
  output logic [31:0] o_Mem_Addr,
  output logic [31:0] o_Mem_Wdata,
  input  logic        i_Mem_Gnt,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Overrun,
  output logic        o_Timeout,
  output logic [15:0] o_Word_Count
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        hold_valid;
  logic [7:0]  hold_byte;
  logic [31:0] word_next;

  if (TIMEOUT_CYCLES < 24'd2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef UART_PROG_TIMEOUT_EN
  logic [23:0] idle_cnt;
`else
  assign o_Timeout = 1'b0;
`endif

  assign o_Clks_Per_Bit = CLKS_PER_BIT_DEF;

  always_comb begin
    word_next = o_Mem_Wdata;
    word_next[8*idx +: 8] = i_Rx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      idx          <= '0;
      hold_valid   <= 1'b0;
      hold_byte    <= '0;
      o_Mem_Req    <= 1'b0;
      o_Mem_Addr   <= BASE_ADDR;
      o_Mem_Wdata  <= '0;
      o_Busy       <= 1'b0;
      o_Done       <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Word_Count <= '0;
`ifdef UART_PROG_TIMEOUT_EN
      o_Timeout    <= 1'b0;
      idle_cnt     <= '0;
`endif
    end else begin
      o_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Start) begin
            state        <= S_COLLECT;
            o_Busy       <= 1'b1;
            o_Mem_Addr   <= BASE_ADDR;
            o_Word_Count <= '0;
            idx          <= '0;
            hold_valid   <= 1'b0;
            o_Overrun    <= 1'b0;
`ifdef UART_PROG_TIMEOUT_EN
            o_Timeout    <= 1'b0;
            idle_cnt     <= '0;
`endif
          end
        end

        S_COLLECT: begin
          if (i_Rx_DV) begin
            o_Mem_Wdata <= word_next;
            idx         <= idx + 2'd1;
`ifdef UART_PROG_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
            if (idx == 2'd3) begin
              if (word_next == END_WORD) begin
                state  <= S_DONE;
                o_Done <= 1'b1;
                o_Busy <= 1'b0;
              end else begin
                state     <= S_WRITE;
                o_Mem_Req <= 1'b1;
              end
            end
          end
`ifdef UART_PROG_TIMEOUT_EN
          else if (idle_cnt == TIMEOUT_CYCLES - 24'd1) begin
            state     <= S_IDLE;
            o_Busy    <= 1'b0;
            idx       <= '0;
            o_Timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 24'd1;
          end
`endif
        end

        S_WRITE: begin
          if (i_Mem_Gnt) begin
            state      <= S_COLLECT;
            o_Mem_Req  <= 1'b0;
            o_Mem_Addr <= o_Mem_Addr + 32'd4;
            if (o_Word_Count != 16'hFFFF) o_Word_Count <= o_Word_Count + 16'd1;
            hold_valid <= 1'b0;
`ifdef UART_PROG_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
            // A byte arriving on the grant cycle is placed directly so it is never lost.
            if (hold_valid && i_Rx_DV) begin
              o_Mem_Wdata[7:0]  <= hold_byte;
              o_Mem_Wdata[15:8] <= i_Rx_Byte;
              idx               <= 2'd2;
            end else if (hold_valid) begin
              o_Mem_Wdata[7:0] <= hold_byte;
              idx              <= 2'd1;
            end else if (i_Rx_DV) begin
              o_Mem_Wdata[7:0] <= i_Rx_Byte;
              idx              <= 2'd1;
            end else begin
              idx <= 2'd0;
            end
          end else if (i_Rx_DV) begin
            if (!hold_valid) begin
              hold_byte  <= i_Rx_Byte;
              hold_valid <= 1'b1;
            end else begin
              o_Overrun <= 1'b1;
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
